afe_init_seq: RTL and testbench

- Parametrised power-up and re-init sequencer for the analog front end.
- Pulses N_RELAY latching-relay coil pairs: first an all-off phase, then a masked-on phase.
- Then streams up to N_SPI register words to the converter through the codebase's existing SPI master, using a request/done handshake.
- Sits between the clock-wizard lock output, the control logic, and the AFE relay and SPI pins. Supports an auto-start on lock and a software re-trigger.

---
 rtl/afe_init_pkg.sv | 30 +++
 rtl/coil_pulse_timer.sv | 34 +++
 rtl/afe_init_seq.sv | 193 +++++++++++++++++++
 tb/tb_afe_init_seq.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afe_init_pkg.sv
// Shared types and coil drive helpers for the AFE power-up / re-init sequencer.
package afe_init_pkg;

    // Sequencer states
    typedef enum logic [3:0] {
        S_IDLE,
        S_OFF_DRV,
        S_OFF_WAIT,
        S_ON_DRV,
        S_ON_WAIT,
        S_RELEASE,
        S_SPI_REQ,
        S_SPI_WAIT,
        S_SPI_GAP,
        S_FIN
    } afe_state_t;

    // Coil codes as {h, l}; both sides are active-low
    localparam logic [1:0] COIL_IDLE = 2'b11;
    localparam logic [1:0] COIL_OFF  = 2'b01;
    localparam logic [1:0] COIL_ON   = 2'b10;

    // Active-phase drive for one relay; inv swaps h and l for common-switch parts
    function automatic logic [1:0] drive(input logic on, input logic inv);
        logic [1:0] w_code;
        w_code = on ? COIL_ON : COIL_OFF;
        return inv ? {w_code[0], w_code[1]} : w_code;
    endfunction

endpackage

// File: rtl/coil_pulse_timer.sv
// Coil pulse length timer shared by the off and on relay phases.
// The load cycle counts as the first drive cycle; o_expired marks the last one.
module coil_pulse_timer
    import afe_init_pkg::*;
#(
    parameter int unsigned PULSE_CYC = 10000,
    parameter int unsigned CNT_W     = 14
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_count,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Saturating drive-cycle counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= ONE;
        end else if (i_count && (r_cnt < LAST)) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign o_expired = (r_cnt >= LAST);

endmodule

// File: rtl/afe_init_seq.sv
// AFE power-up / re-init sequencer: pulses relay coils off then masked-on,
// then streams register words to the external SPI master.
module afe_init_seq
    import afe_init_pkg::*;
#(
    parameter int unsigned         N_RELAY    = 5,
    parameter logic [N_RELAY-1:0]  INV_MASK   = 5'b10000,
    parameter int unsigned         PULSE_CYC  = 10000,
    parameter int unsigned         N_SPI      = 4,
    parameter int unsigned         SPI_W      = 24,
    parameter int unsigned         GAP_CYC    = 8,
    parameter bit                  AUTO_START = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         locked,
    input  logic                         start,
    input  logic [N_RELAY-1:0]           on_mask,
    input  logic [N_SPI*SPI_W-1:0]       spi_words,
    input  logic [$clog2(N_SPI+1)-1:0]   spi_count,
    output logic [N_RELAY-1:0]           relay_h,
    output logic [N_RELAY-1:0]           relay_l,
    output logic                         spi_act,
    output logic [SPI_W-1:0]             spi_tx_data,
    input  logic                         spi_done,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned       CNT_W    = $clog2(PULSE_CYC + GAP_CYC + 1);
    localparam int unsigned       IDX_W    = $clog2(N_SPI + 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(N_SPI);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    afe_state_t        r_state;
    afe_state_t        w_next;
    logic              r_armed;
    logic [N_RELAY-1:0] r_mask;
    logic [SPI_W-1:0]  r_words [N_SPI];
    logic [IDX_W-1:0]  r_count;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_gap;
    logic [SPI_W-1:0]  r_tx;

    logic              w_trigger;
    logic              w_pulse_expired;
    logic              w_tmr_load;
    logic              w_tmr_count;
    logic              w_last_word;
    logic              w_gap_done;
    logic [IDX_W-1:0]  w_count_clamped;
    logic [IDX_W-1:0]  w_tx_idx;
    logic [SPI_W-1:0]  w_tx_word;
    logic [1:0]        w_code;

    assign w_trigger       = (r_state == S_IDLE) && (start || (r_armed && locked));
    assign w_tmr_load      = (r_state == S_OFF_DRV) || (r_state == S_ON_DRV);
    assign w_tmr_count     = (r_state == S_OFF_WAIT) || (r_state == S_ON_WAIT);
    assign w_last_word     = ((r_idx + IDX_ONE) == r_count);
    assign w_gap_done      = (r_gap >= GAP_LAST);
    assign w_count_clamped = (spi_count > IDX_MAX) ? IDX_MAX : spi_count;

    coil_pulse_timer #(
        .PULSE_CYC (PULSE_CYC),
        .CNT_W     (CNT_W)
    ) u_coil_timer (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_load    (w_tmr_load),
        .i_count   (w_tmr_count),
        .o_expired (w_pulse_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; single-cycle pulses skip the wait states entirely
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_trigger) w_next = S_OFF_DRV;
            S_OFF_DRV:  w_next = (PULSE_CYC <= 1) ? S_ON_DRV : S_OFF_WAIT;
            S_OFF_WAIT: if (w_pulse_expired) w_next = S_ON_DRV;
            S_ON_DRV:   w_next = (PULSE_CYC <= 1) ? S_RELEASE : S_ON_WAIT;
            S_ON_WAIT:  if (w_pulse_expired) w_next = S_RELEASE;
            S_RELEASE:  w_next = (r_count == '0) ? S_FIN : S_SPI_REQ;
            S_SPI_REQ:  w_next = S_SPI_WAIT;
            S_SPI_WAIT: begin
                if (spi_done) begin
                    if (w_last_word)       w_next = S_FIN;
                    else if (GAP_CYC == 0) w_next = S_SPI_REQ;
                    else                   w_next = S_SPI_GAP;
                end
            end
            S_SPI_GAP:  if (w_gap_done) w_next = S_SPI_REQ;
            S_FIN:      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Trigger-time capture of the sequence configuration and auto-start arming
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= AUTO_START;
            r_mask  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < N_SPI; i++) begin
                r_words[i] <= '0;
            end
        end else if (w_trigger) begin
            r_armed <= 1'b0;
            r_mask  <= on_mask;
            r_count <= w_count_clamped;
            for (int unsigned i = 0; i < N_SPI; i++) begin
                r_words[i] <= spi_words[i*SPI_W +: SPI_W];
            end
        end
    end

    // Word index and inter-word gap counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_gap <= '0;
        end else begin
            if (r_state == S_RELEASE) begin
                r_idx <= '0;
            end else if ((r_state == S_SPI_WAIT) && spi_done) begin
                r_idx <= r_idx + IDX_ONE;
            end
            if (r_state == S_SPI_WAIT) begin
                r_gap <= CNT_ONE;
            end else if ((r_state == S_SPI_GAP) && !w_gap_done) begin
                r_gap <= r_gap + CNT_ONE;
            end
        end
    end

    // Index of the word about to be requested; a zero-gap hop from SPI_WAIT
    // arrives before r_idx has advanced, so look one word ahead there
    always_comb begin
        w_tx_idx = r_idx;
        if (r_state == S_RELEASE) begin
            w_tx_idx = '0;
        end else if (r_state == S_SPI_WAIT) begin
            w_tx_idx = r_idx + IDX_ONE;
        end
        w_tx_word = '0;
        for (int unsigned i = 0; i < N_SPI; i++) begin
            if (IDX_W'(i) == w_tx_idx) w_tx_word = r_words[i];
        end
    end

    // Transmit word register, loaded on entry to SPI_REQ and held through the transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx <= '0;
        end else if ((w_next == S_SPI_REQ) && (r_state != S_SPI_REQ)) begin
            r_tx <= w_tx_word;
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        relay_h = '1;
        relay_l = '1;
        w_code  = COIL_IDLE;
        for (int unsigned k = 0; k < N_RELAY; k++) begin
            w_code = COIL_IDLE;
            case (r_state)
                S_OFF_DRV, S_OFF_WAIT: w_code = drive(1'b0, INV_MASK[k]);
                S_ON_DRV, S_ON_WAIT:   if (r_mask[k]) w_code = drive(1'b1, INV_MASK[k]);
                default:               w_code = COIL_IDLE;
            endcase
            relay_h[k] = w_code[1];
            relay_l[k] = w_code[0];
        end
        spi_act = (r_state == S_SPI_REQ);
        busy    = (r_state != S_IDLE) && (r_state != S_FIN);
        done    = (r_state == S_FIN);
    end

    assign spi_tx_data = r_tx;

endmodule

// File: tb/tb_afe_init_seq.sv
// Self-checking bench for afe_init_seq with a timeline-based reference model.
module tb_afe_init_seq;

    localparam int unsigned NR = 5;
    localparam int unsigned NS = 4;
    localparam int unsigned SW = 24;
    localparam int unsigned PC = 4;
    localparam int unsigned GC = 8;
    localparam logic [NR-1:0] INV = 5'b10000;
    localparam logic [NR-1:0] OFF_H = 5'b10000;
    localparam logic [NR-1:0] OFF_L = 5'b01111;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              locked = 1'b0;
    logic              start = 1'b0;
    logic [NR-1:0]     on_mask = '0;
    logic [NS*SW-1:0]  spi_words = '0;
    logic [2:0]        spi_count = '0;
    logic [NR-1:0]     relay_h;
    logic [NR-1:0]     relay_l;
    logic              spi_act;
    logic [SW-1:0]     spi_tx_data;
    logic              spi_done = 1'b0;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    afe_init_seq #(
        .N_RELAY    (NR),
        .INV_MASK   (INV),
        .PULSE_CYC  (PC),
        .N_SPI      (NS),
        .SPI_W      (SW),
        .GAP_CYC    (GC),
        .AUTO_START (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .locked      (locked),
        .start       (start),
        .on_mask     (on_mask),
        .spi_words   (spi_words),
        .spi_count   (spi_count),
        .relay_h     (relay_h),
        .relay_l     (relay_l),
        .spi_act     (spi_act),
        .spi_tx_data (spi_tx_data),
        .spi_done    (spi_done),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // ---------------- reference model (timeline since trigger) ----------------
    bit              m_armed = 1'b1;
    bit              m_active = 1'b0;
    bit              m_wait = 1'b0;
    int              m_t = 0;
    int              m_req_at = -1;
    int              m_fin_at = -1;
    int              m_sent = 0;
    int              m_count = 0;
    logic [NR-1:0]   m_mask = '0;
    logic [SW-1:0]   m_words [NS];

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_armed  = 1'b1;
                m_active = 1'b0;
                m_wait   = 1'b0;
            end else if (!m_active) begin
                if (start || (m_armed && locked)) begin
                    m_armed  = 1'b0;
                    m_active = 1'b1;
                    m_t      = 1;
                    m_mask   = on_mask;
                    m_count  = (int'(spi_count) > NS) ? NS : int'(spi_count);
                    for (int i = 0; i < NS; i++) m_words[i] = spi_words[i*SW +: SW];
                    m_sent   = 0;
                    m_wait   = 1'b0;
                    // relays occupy cycles 1..2*PC, release is 2*PC+1
                    if (m_count == 0) begin
                        m_fin_at = 2*PC + 2;
                        m_req_at = -1;
                    end else begin
                        m_req_at = 2*PC + 2;
                        m_fin_at = -1;
                    end
                end
            end else if (m_t == m_fin_at) begin
                m_active = 1'b0;
            end else begin
                if (m_t == m_req_at) begin
                    m_wait = 1'b1;
                end else if (m_wait && spi_done) begin
                    m_wait = 1'b0;
                    m_sent++;
                    if (m_sent == m_count) m_fin_at = m_t + 1;
                    else                   m_req_at = m_t + 1 + GC;
                end
                m_t++;
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial begin
        logic [NR-1:0] e_h, e_l;
        logic e_busy, e_done, e_act;
        forever begin
            @(negedge clk);
            e_h = '1;
            e_l = '1;
            if (m_active) begin
                for (int k = 0; k < NR; k++) begin
                    if (m_t >= 1 && m_t <= PC) begin
                        e_h[k] = INV[k];
                        e_l[k] = ~INV[k];
                    end else if (m_t > PC && m_t <= 2*PC && m_mask[k]) begin
                        e_h[k] = ~INV[k];
                        e_l[k] = INV[k];
                    end
                end
            end
            e_busy = m_active && (m_t != m_fin_at);
            e_done = m_active && (m_t == m_fin_at);
            e_act  = m_active && (m_t == m_req_at);
            check("relay_h", 32'(relay_h), 32'(e_h));
            check("relay_l", 32'(relay_l), 32'(e_l));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("spi_act", 32'(spi_act), 32'(e_act));
            if (m_active && (e_act || m_wait))
                check("spi_tx_data", 32'(spi_tx_data), 32'(m_words[m_sent]));
        end
    end

    // ---------------- SPI master stand-in ----------------
    int  lat = 5;
    bit  rand_lat = 1'b0;
    bit  stray_en = 1'b0;
    initial begin
        int cd;
        cd = 0;
        forever begin
            @(negedge clk);
            spi_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) spi_done = 1'b1;
            end else if (stray_en && ($urandom_range(0, 7) == 0)) begin
                spi_done = 1'b1;
            end
            if (spi_act) cd = rand_lat ? int'($urandom_range(1, 12)) : lat;
        end
    end

    // ---------------- monitor for hand-computed expectations ----------------
    int            mon_off, mon_on, mon_done, mon_act, mon_unstable, mon_last_act, mon_min_gap;
    logic [NR-1:0] mon_on_h = '1;
    logic [NR-1:0] mon_on_l = '1;
    logic [SW-1:0] mon_tx [$];
    bit            mon_hold = 1'b0;
    logic [SW-1:0] mon_hold_val = '0;

    task automatic clear_mon();
        mon_off = 0; mon_on = 0; mon_done = 0; mon_act = 0; mon_unstable = 0;
        mon_last_act = -1; mon_min_gap = 1000000; mon_hold = 1'b0;
        mon_tx.delete();
    endtask

    initial begin
        clear_mon();
        forever begin
            @(negedge clk);
            if (relay_h == OFF_H && relay_l == OFF_L) mon_off++;
            if (relay_h == mon_on_h && relay_l == mon_on_l) mon_on++;
            if (done) mon_done++;
            if (spi_act) begin
                mon_act++;
                mon_tx.push_back(spi_tx_data);
                if (mon_last_act >= 0 && (cyc - mon_last_act) < mon_min_gap) mon_min_gap = cyc - mon_last_act;
                mon_last_act = cyc;
                mon_hold = 1'b1;
                mon_hold_val = spi_tx_data;
            end else if (mon_hold && spi_tx_data != mon_hold_val) begin
                mon_unstable++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (spi_done || rst) mon_hold = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: done got 0 expected 1 within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_act(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (spi_act) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: spi_act got 0 expected 1 within %0d cycles", name, budget);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [SW-1:0] w0, w1, w2, w3;
        w0 = 24'h000121; w1 = 24'h001421; w2 = 24'h00FF01; w3 = 24'hABCDEF;

        // Reset state
        on_mask = 5'b10001;
        tick(3);
        check("rst_relay_h", 32'(relay_h), 32'h1F);
        check("rst_relay_l", 32'(relay_l), 32'h1F);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_tx", 32'(spi_tx_data), 32'h0);

        // Auto-start on lock, no SPI words
        rst = 1'b0;
        tick(2);
        clear_mon();
        mon_on_h = 5'b01111;
        mon_on_l = 5'b11110;
        locked = 1'b1;
        wait_done(60, "auto_done");
        tick(2);
        check("auto_off_cycles", 32'(mon_off), 32'd4);
        check("auto_on_cycles", 32'(mon_on), 32'd4);
        check("auto_done_count", 32'(mon_done), 32'd1);
        check("auto_act_count", 32'(mon_act), 32'd0);
        locked = 1'b0;
        tick(3);
        locked = 1'b1;
        tick(40);
        check("relock_no_rerun", 32'(mon_done), 32'd1);
        check("relock_busy", 32'(busy), 32'h0);

        // Masked on phase plus three SPI words
        on_mask   = 5'b00101;
        mon_on_h  = 5'b11111;
        mon_on_l  = 5'b11010;
        spi_words = {w3, w2, w1, w0};
        spi_count = 3'd3;
        clear_mon();
        pulse_start();
        wait_done(300, "spi3_done");
        tick(2);
        check("spi3_on_cycles", 32'(mon_on), 32'd4);
        check("spi3_act_count", 32'(mon_act), 32'd3);
        if (mon_tx.size() == 3) begin
            check("spi3_word0", 32'(mon_tx[0]), 32'h000121);
            check("spi3_word1", 32'(mon_tx[1]), 32'h001421);
            check("spi3_word2", 32'(mon_tx[2]), 32'h00FF01);
        end
        check("spi3_gap_ok", 32'(mon_min_gap >= int'(GC)), 32'd1);
        check("spi3_tx_stable", 32'(mon_unstable), 32'd0);
        check("spi3_done_count", 32'(mon_done), 32'd1);

        // Zero words
        spi_count = 3'd0;
        clear_mon();
        pulse_start();
        wait_done(60, "cnt0_done");
        tick(2);
        check("cnt0_act_count", 32'(mon_act), 32'd0);
        check("cnt0_done_count", 32'(mon_done), 32'd1);

        // Count above N_SPI clamps to four words
        spi_count = 3'd7;
        clear_mon();
        pulse_start();
        wait_done(400, "cnt7_done");
        tick(2);
        check("cnt7_act_count", 32'(mon_act), 32'd4);
        if (mon_tx.size() == 4) check("cnt7_word3", 32'(mon_tx[3]), 32'hABCDEF);
        check("cnt7_done_count", 32'(mon_done), 32'd1);

        // start during ON_WAIT is dropped
        spi_count = 3'd1;
        clear_mon();
        pulse_start();
        tick(5);
        pulse_start();
        wait_done(100, "onwait_done");
        tick(40);
        check("onwait_off_cycles", 32'(mon_off), 32'd4);
        check("onwait_on_cycles", 32'(mon_on), 32'd4);
        check("onwait_done_count", 32'(mon_done), 32'd1);

        // Reset in SPI_WAIT, then explicit rerun
        locked = 1'b0;
        spi_count = 3'd2;
        pulse_start();
        wait_act(60, "rstwait_act");
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rstwait_busy", 32'(busy), 32'h0);
        check("rstwait_relay_h", 32'(relay_h), 32'h1F);
        check("rstwait_relay_l", 32'(relay_l), 32'h1F);
        check("rstwait_tx", 32'(spi_tx_data), 32'h0);
        tick(8);
        clear_mon();
        pulse_start();
        wait_done(200, "rerun_done");
        tick(2);
        check("rerun_off_cycles", 32'(mon_off), 32'd4);
        check("rerun_act_count", 32'(mon_act), 32'd2);

        // Randomised traffic; the model checks every cycle
        rand_lat = 1'b1;
        stray_en = 1'b1;
        for (int it = 0; it < 4000; it++) begin
            rst       = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) locked = ~locked;
            on_mask   = NR'($urandom);
            spi_words = {$urandom, $urandom, $urandom};
            spi_count = 3'($urandom_range(0, 7));
            tick(1);
        end
        rst = 1'b0;
        start = 1'b0;
        tick(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
